wash_panel_ctrl: RTL and testbench
==================================

// Module: wash_panel_ctrl
// PURPOSE
//  User-panel front end of the washer. Debounces raw buttons and switches, and
//  latches the program choice. Issues the start/power/door/soap inputs that FSMW
//  consumes. Consumes FSMW status (timer_display, program_done, soap_warning)
//  and drives the BCD display, door lock and buzzer.
// PARAMETERS
//  DEB_CYCLES       4   consecutive identical samples needed to accept a raw input change
//  ALARM_CYCLES     16  buzzer-on duration after program completion
//  LOCK_HOLD_CYCLES 32  start-hold time that toggles child lock (CHILD_LOCK_EN only)
// PORTS
//  clk                in  1  system clock
//  rst                in  1  synchronous, active-low reset
//  power_sw_raw       in  1  raw power switch (level)
//  door_sw_raw        in  1  raw door switch, 1 = closed
//  soap_sw_raw        in  1  raw soap-present sensor
//  btn_start_raw      in  1  raw start button, 1 = pressed
//  btn_prog_raw       in  1  raw program-cycle button
//  btn_cancel_raw     in  1  raw cancel button
//  timer_display      in  8  remaining-time count from FSMW
//  program_done       in  1  FSMW completion level
//  soap_warning       in  1  FSMW soap-missing level
//  power / doorclosed / soap  out 1 each  debounced levels to FSMW
//  program_selection  out 3  latched program code to FSMW
//  start              out 1  one-cycle start pulse to FSMW
//  ctrl_rst           out 1  active-high reset to FSMW
//  door_lock          out 1  door latch solenoid
//  disp_hund / disp_tens / disp_ones  out 4 each  BCD digits
//  soap_led           out 1  registered copy of soap_warning
//  buzzer             out 1  completion alarm
//  child_lock         out 1  child-lock indicator (tied 0 without CHILD_LOCK_EN)
//  panel_state        out 2  current state code, for debug
// BEHAVIOUR
//  Reset values (rst=0 at clk): all outputs 0, except ctrl_rst=1. State=SELECT,
//  program_selection=COLD_WASH. Debouncer counters are cleared and their outputs are 0.
//  ctrl_rst drops 1 cycle after the first clk with rst=1.
//  Debounce: a debounced output takes a new raw value after DEB_CYCLES equal samples.
//  Button press = debounced 0->1 edge, a 1-cycle internal pulse.
//  The debounced levels of the power, door and soap switches drive the outputs directly.
//  Total input-to-press latency: DEB_CYCLES+1 cycles.
//  FSM states (panel_state): SELECT=0, RUNNING=1, ALARM=2.
//   SELECT:  prog press -> selection 0->1->2->3->0 (wrap).
//            start press with power&doorclosed -> start=1 for 1 cycle, go to RUNNING.
//            start press otherwise is ignored.
//            start and prog press in the same cycle: start wins, selection unchanged.
//            Display shows 000.
//   RUNNING: selection frozen; prog/start presses ignored; door_lock=1.
//            program_done 0->1 edge -> ALARM.
//            cancel press or power drop -> ctrl_rst=1 for 1 cycle, go to SELECT.
//            cancel and done edge in the same cycle: cancel wins.
//   ALARM:   buzzer=1, door_lock=0. Leaves for SELECT after ALARM_CYCLES, or
//            earlier on any button press.
//  Display: timer_display is converted to 3 BCD digits by double-dabble, with 1-cycle
//   registered latency. Display valid only in RUNNING; forced to 0 otherwise.
//   Max input 255 -> 2,5,5.
//  soap_led tracks soap_warning with 1-cycle delay; it has no effect on the FSM.
// CONFIGURATION
//  WASH_PANEL_CHILD_LOCK_EN defined: in RUNNING, holding start (debounced) for
//   LOCK_HOLD_CYCLES toggles child_lock. Toggle once per hold.
//   While child_lock=1, cancel presses are ignored; a power drop still aborts.
//   child_lock is cleared on entry to SELECT.
//  Undefined: no hold counter is built, child_lock=0, cancel always honoured.
// STRUCTURE
//  Package wash_pkg holds the program codes (COLD_WASH=0, HOT_WASH=1,
//   RINSING_DRY=2, ONLY_DRY=3) and the panel state codes, shared with FSMW.
//  Sub-module wash_debounce (param DEB_CYCLES) is instantiated 6x, once per raw input.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> ctrl_rst=1, state SELECT, selection=0, disp=000.
//  2 Bounce: btn_prog toggles every cycle for 10 cycles, then held 1
//    -> exactly one increment, 0->1.
//  3 Five prog presses -> selection 0,1,2,3,0,1 (wrap).
//    Start with door open -> no start pulse; close door, start -> 1-cycle start,
//    RUNNING, door_lock=1.
//  4 RUNNING, timer_display=8'd137 -> disp_hund/tens/ones = 1,3,7 one cycle later.
//    Then program_done=1 -> buzzer high for 16 cycles, then SELECT.
//  5 RUNNING, cancel press coincident with program_done edge
//    -> ctrl_rst pulse, SELECT, buzzer stays 0.
//  6 CHILD_LOCK_EN: hold start 32+ cycles in RUNNING -> child_lock=1, cancel ignored;
//    power drop -> SELECT, child_lock=0.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the washer panel and FSMW: program codes, panel
// state codes and a binary-to-BCD helper.
package wash_pkg;

  typedef enum logic [1:0] {
    COLD_WASH   = 2'd0,
    HOT_WASH    = 2'd1,
    RINSING_DRY = 2'd2,
    ONLY_DRY    = 2'd3
  } prog_e;

  typedef enum logic [1:0] {
    SELECT  = 2'd0,
    RUNNING = 2'd1,
    ALARM   = 2'd2
  } panel_state_e;

  // Double-dabble: add 3 to any digit >= 5 before each left shift.
  function automatic logic [11:0] bin_to_bcd(input logic [7:0] bin);
    logic [11:0] bcd;
    bcd = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5)  bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4] >= 4'd5)  bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/wash_debounce.sv
// Single-input debouncer: the output adopts a new raw level only after
// DEB_CYCLES consecutive samples that all differ from the current output.
// Raw inputs are assumed to be already synchronised to clk.
module wash_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Count samples disagreeing with the output; any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (raw_i != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = raw_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and accepted level registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/wash_panel_ctrl.sv
// Washer user-panel front end: debounces the six raw inputs, latches the
// program choice, sequences SELECT/RUNNING/ALARM, drives BCD display, door
// lock and buzzer. Optional child lock is built when WASH_PANEL_CHILD_LOCK_EN
// is defined.
module wash_panel_ctrl
  import wash_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int ALARM_CYCLES = 16
`ifdef WASH_PANEL_CHILD_LOCK_EN
  ,
  parameter int LOCK_HOLD_CYCLES = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_sw_raw,
  input  logic       door_sw_raw,
  input  logic       soap_sw_raw,
  input  logic       btn_start_raw,
  input  logic       btn_prog_raw,
  input  logic       btn_cancel_raw,
  input  logic [7:0] timer_display,
  input  logic       program_done,
  input  logic       soap_warning,
  output logic       power,
  output logic       doorclosed,
  output logic       soap,
  output logic [2:0] program_selection,
  output logic       start,
  output logic       ctrl_rst,
  output logic       door_lock,
  output logic [3:0] disp_hund,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       soap_led,
  output logic       buzzer,
  output logic       child_lock,
  output logic [1:0] panel_state
);

  localparam int AW = $clog2(ALARM_CYCLES + 1);

  // Bit order: 0 power, 1 door, 2 soap, 3 start, 4 prog, 5 cancel.
  logic [5:0] raw_vec, lvl_vec;
  assign raw_vec = {btn_cancel_raw, btn_prog_raw, btn_start_raw,
                    soap_sw_raw, door_sw_raw, power_sw_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_deb
      wash_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (raw_vec[gi]),
        .level_o (lvl_vec[gi])
      );
    end
  endgenerate

  panel_state_e  state_q, state_d;
  prog_e         sel_q, sel_d;
  logic          start_q, start_d;
  logic          ctrl_rst_q, ctrl_rst_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [2:0]    btn_prev_q;
  logic          done_prev_q;
  logic [11:0]   disp_q;
  logic          soap_led_q;
  logic          child_lock_w;

  logic start_press, prog_press, cancel_press, any_press, done_edge;
  assign start_press  = lvl_vec[3] & ~btn_prev_q[0];
  assign prog_press   = lvl_vec[4] & ~btn_prev_q[1];
  assign cancel_press = lvl_vec[5] & ~btn_prev_q[2];
  assign any_press    = start_press | prog_press | cancel_press;
  assign done_edge    = program_done & ~done_prev_q;

  // Next-state and registered-output logic of the panel sequencer.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    start_d     = 1'b0;
    ctrl_rst_d  = 1'b0;
    alarm_cnt_d = alarm_cnt_q;
    case (state_q)
      SELECT: begin
        if (start_press) begin
          if (lvl_vec[0] && lvl_vec[1]) begin
            start_d = 1'b1;
            state_d = RUNNING;
          end
        end else if (prog_press) begin
          sel_d = prog_e'(sel_q + 2'd1);
        end
      end
      RUNNING: begin
        if ((cancel_press && !child_lock_w) || !lvl_vec[0]) begin
          ctrl_rst_d = 1'b1;
          state_d    = SELECT;
        end else if (done_edge) begin
          state_d     = ALARM;
          alarm_cnt_d = '0;
        end
      end
      ALARM: begin
        if (any_press || alarm_cnt_q == AW'(ALARM_CYCLES - 1)) begin
          state_d = SELECT;
        end else begin
          alarm_cnt_d = alarm_cnt_q + AW'(1);
        end
      end
      default: state_d = SELECT;
    endcase
  end

  // State, edge-detect history, display and soap LED registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SELECT;
      sel_q       <= COLD_WASH;
      start_q     <= 1'b0;
      ctrl_rst_q  <= 1'b1;
      alarm_cnt_q <= '0;
      btn_prev_q  <= '0;
      done_prev_q <= 1'b0;
      disp_q      <= '0;
      soap_led_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      ctrl_rst_q  <= ctrl_rst_d;
      alarm_cnt_q <= alarm_cnt_d;
      btn_prev_q  <= lvl_vec[5:3];
      done_prev_q <= program_done;
      disp_q      <= bin_to_bcd(timer_display);
      soap_led_q  <= soap_warning;
    end
  end

`ifdef WASH_PANEL_CHILD_LOCK_EN
  localparam int HW = $clog2(LOCK_HOLD_CYCLES + 1);
  logic [HW-1:0] hold_cnt_q;
  logic          child_lock_q;

  // Hold counter saturates past the threshold so one long hold toggles only once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt_q   <= '0;
      child_lock_q <= 1'b0;
    end else begin
      if (state_q == RUNNING && lvl_vec[3]) begin
        if (hold_cnt_q == HW'(LOCK_HOLD_CYCLES - 1)) begin
          hold_cnt_q   <= HW'(LOCK_HOLD_CYCLES);
          child_lock_q <= ~child_lock_q;
        end else if (hold_cnt_q != HW'(LOCK_HOLD_CYCLES)) begin
          hold_cnt_q <= hold_cnt_q + HW'(1);
        end
      end else begin
        hold_cnt_q <= '0;
      end
      if (state_d == SELECT) child_lock_q <= 1'b0;
    end
  end
  assign child_lock_w = child_lock_q;
`else
  assign child_lock_w = 1'b0;
`endif

  assign power             = lvl_vec[0];
  assign doorclosed        = lvl_vec[1];
  assign soap              = lvl_vec[2];
  assign program_selection = {1'b0, sel_q};
  assign start             = start_q;
  assign ctrl_rst          = ctrl_rst_q;
  assign door_lock         = (state_q == RUNNING);
  assign buzzer            = (state_q == ALARM);
  assign {disp_hund, disp_tens, disp_ones} = (state_q == RUNNING) ? disp_q : 12'd0;
  assign soap_led          = soap_led_q;
  assign child_lock        = child_lock_w;
  assign panel_state       = state_q;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Self-checking bench for wash_panel_ctrl: directed sequences, a BCD vector
// table and randomized stimulus, all compared every cycle against a
// behavioural model. Child-lock sequence runs when WASH_PANEL_CHILD_LOCK_EN is defined.
module tb_wash_panel_ctrl;

  localparam int DEB     = 4;
  localparam int ALARM_N = 16;
  localparam int LOCK_N  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       power_sw_raw = 0, door_sw_raw = 0, soap_sw_raw = 0;
  logic       btn_start_raw = 0, btn_prog_raw = 0, btn_cancel_raw = 0;
  logic [7:0] timer_display = 8'd0;
  logic       program_done = 0, soap_warning = 0;

  logic       power, doorclosed, soap, start, ctrl_rst, door_lock;
  logic [2:0] program_selection;
  logic [3:0] disp_hund, disp_tens, disp_ones;
  logic       soap_led, buzzer, child_lock;
  logic [1:0] panel_state;

  always #5 clk = ~clk;

  wash_panel_ctrl dut (
    .clk(clk), .rst(rst),
    .power_sw_raw(power_sw_raw), .door_sw_raw(door_sw_raw), .soap_sw_raw(soap_sw_raw),
    .btn_start_raw(btn_start_raw), .btn_prog_raw(btn_prog_raw), .btn_cancel_raw(btn_cancel_raw),
    .timer_display(timer_display), .program_done(program_done), .soap_warning(soap_warning),
    .power(power), .doorclosed(doorclosed), .soap(soap),
    .program_selection(program_selection), .start(start), .ctrl_rst(ctrl_rst),
    .door_lock(door_lock), .disp_hund(disp_hund), .disp_tens(disp_tens), .disp_ones(disp_ones),
    .soap_led(soap_led), .buzzer(buzzer), .child_lock(child_lock), .panel_state(panel_state)
  );

  int tests = 0;
  int fails = 0;
  int start_seen = 0;
  int buz_seen = 0;

  // ---------------- behavioural reference model ----------------
  // Inputs indexed 0 power, 1 door, 2 soap, 3 start, 4 prog, 5 cancel.
  bit m_lvl[6], m_lvl_d[6], m_last[6];
  int m_run[6];
  int m_st = 0, m_sel = 0, m_alarm_n = 0, m_hold_n = 0, m_timer = 0;
  bit m_start = 0, m_crst = 1, m_cl = 0, m_done_prev = 0, m_soap_led = 0;

  task automatic model_step();
    bit raw[6];
    bit ps, pp, pc, de;
    int nst;
    raw[0] = power_sw_raw; raw[1] = door_sw_raw;   raw[2] = soap_sw_raw;
    raw[3] = btn_start_raw; raw[4] = btn_prog_raw; raw[5] = btn_cancel_raw;
    if (!rst) begin
      for (int k = 0; k < 6; k++) begin
        m_lvl[k] = 0; m_lvl_d[k] = 0; m_last[k] = 0; m_run[k] = 0;
      end
      m_st = 0; m_sel = 0; m_alarm_n = 0; m_hold_n = 0; m_timer = 0;
      m_start = 0; m_crst = 1; m_cl = 0; m_done_prev = 0; m_soap_led = 0;
      return;
    end
    ps = m_lvl[3] && !m_lvl_d[3];
    pp = m_lvl[4] && !m_lvl_d[4];
    pc = m_lvl[5] && !m_lvl_d[5];
    de = program_done && !m_done_prev;
    nst = m_st;
    m_start = 0;
    m_crst = 0;
    case (m_st)
      0: if (ps) begin
           if (m_lvl[0] && m_lvl[1]) begin m_start = 1; nst = 1; end
         end else if (pp) m_sel = (m_sel + 1) % 4;
      1: if ((pc && !m_cl) || !m_lvl[0]) begin m_crst = 1; nst = 0; end
         else if (de) begin nst = 2; m_alarm_n = 0; end
      default: begin
        m_alarm_n++;
        if (ps || pp || pc || m_alarm_n == ALARM_N) nst = 0;
      end
    endcase
`ifdef WASH_PANEL_CHILD_LOCK_EN
    if (m_st == 1 && m_lvl[3]) begin
      m_hold_n++;
      if (m_hold_n == LOCK_N) m_cl = !m_cl;
    end else m_hold_n = 0;
    if (nst == 0) m_cl = 0;
`endif
    m_st = nst;
    m_done_prev = program_done;
    m_soap_led = soap_warning;
    m_timer = int'(timer_display);
    // A level is accepted once the last DEB raw samples agree on a new value.
    for (int k = 0; k < 6; k++) begin
      m_lvl_d[k] = m_lvl[k];
      if (raw[k] == m_last[k]) m_run[k]++;
      else begin m_last[k] = raw[k]; m_run[k] = 1; end
      if (m_run[k] >= DEB && raw[k] != m_lvl[k]) m_lvl[k] = raw[k];
    end
  endtask

  function automatic logic [25:0] exp_vec();
    logic [11:0] digits;
    digits = (m_st == 1) ? {4'(m_timer / 100), 4'((m_timer / 10) % 10), 4'(m_timer % 10)} : 12'd0;
    return {m_lvl[0], m_lvl[1], m_lvl[2], 3'(m_sel), m_start, m_crst, (m_st == 1),
            digits, m_soap_led, (m_st == 2), m_cl, 2'(m_st)};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {power, doorclosed, soap, program_selection, start, ctrl_rst, door_lock,
            disp_hund, disp_tens, disp_ones, soap_led, buzzer, child_lock, panel_state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model and DUT both take the edge, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_vec", 32'(dut_vec()), 32'(exp_vec()));
    if (start) start_seen++;
    if (buzzer) buz_seen++;
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_start_raw = v;
      1: btn_prog_raw = v;
      default: btn_cancel_raw = v;
    endcase
  endtask

  // Clean press: held long enough to register, released long enough to settle.
  task automatic press(input int which);
    set_btn(which, 1'b1);
    cycles(DEB + 2);
    set_btn(which, 1'b0);
    cycles(DEB + 2);
  endtask

  typedef struct {
    logic [7:0]  t;
    logic [11:0] bcd;
  } bcd_vec_t;

  bcd_vec_t vecs[8];
  int exp_sel[5];

  initial begin
    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd5,   12'h005};
    vecs[2] = '{8'd9,   12'h009};
    vecs[3] = '{8'd10,  12'h010};
    vecs[4] = '{8'd99,  12'h099};
    vecs[5] = '{8'd100, 12'h100};
    vecs[6] = '{8'd200, 12'h200};
    vecs[7] = '{8'd255, 12'h255};
    exp_sel = '{1, 2, 3, 0, 1};

    // Reset state
    rst = 1'b0;
    cycles(2);
    check("rst_ctrl_rst", 32'(ctrl_rst), 32'd1);
    check("rst_state", 32'(panel_state), 32'd0);
    check("rst_sel", 32'(program_selection), 32'd0);
    check("rst_disp", 32'({disp_hund, disp_tens, disp_ones}), 32'd0);
    rst = 1'b1;
    cycle();
    check("ctrl_rst_release", 32'(ctrl_rst), 32'd0);

    // Bouncing program button, then a clean hold: exactly one increment
    for (int i = 0; i < 10; i++) begin
      btn_prog_raw = ~btn_prog_raw;
      cycle();
    end
    check("bounce_no_inc", 32'(program_selection), 32'd0);
    btn_prog_raw = 1'b1;
    cycles(DEB + 3);
    btn_prog_raw = 1'b0;
    cycles(DEB + 2);
    check("bounce_one_inc", 32'(program_selection), 32'd1);

    // Five presses from a fresh reset wrap 0->1->2->3->0->1
    rst = 1'b0; cycles(2); rst = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin
      press(1);
      check("prog_wrap", 32'(program_selection), 32'(exp_sel[i]));
    end

    // Start with door open is ignored; with door closed it starts
    power_sw_raw = 1'b1; door_sw_raw = 1'b0;
    cycles(DEB + 2);
    start_seen = 0;
    press(0);
    check("start_door_open_pulses", 32'(start_seen), 32'd0);
    check("start_door_open_state", 32'(panel_state), 32'd0);
    door_sw_raw = 1'b1;
    cycles(DEB + 2);
    start_seen = 0;
    press(0);
    check("start_pulse_count", 32'(start_seen), 32'd1);
    check("running_state", 32'(panel_state), 32'd1);
    check("door_lock_on", 32'(door_lock), 32'd1);
    check("sel_kept", 32'(program_selection), 32'd1);

    // Display latency and BCD table
    timer_display = 8'd137;
    cycle();
    check("disp_137", 32'({disp_hund, disp_tens, disp_ones}), 32'h137);
    for (int i = 0; i < 8; i++) begin
      timer_display = vecs[i].t;
      cycle();
      check("disp_table", 32'({disp_hund, disp_tens, disp_ones}), 32'(vecs[i].bcd));
    end

    // Completion: 16 buzzer cycles then back to SELECT
    buz_seen = 0;
    program_done = 1'b1;
    cycle();
    check("alarm_entry", 32'(panel_state), 32'd2);
    check("alarm_door_unlock", 32'(door_lock), 32'd0);
    for (int i = 0; i < 40 && panel_state != 2'd0; i++) cycle();
    check("alarm_exit_state", 32'(panel_state), 32'd0);
    check("buzzer_cycles", 32'(buz_seen), 32'(ALARM_N));
    check("disp_off_select", 32'({disp_hund, disp_tens, disp_ones}), 32'd0);
    program_done = 1'b0;
    cycle();

    // Cancel coincident with done edge: cancel wins
    press(0);
    check("rerun_state", 32'(panel_state), 32'd1);
    btn_cancel_raw = 1'b1;
    cycles(DEB);
    program_done = 1'b1;
    cycle();
    check("cancel_ctrl_rst", 32'(ctrl_rst), 32'd1);
    check("cancel_state", 32'(panel_state), 32'd0);
    check("cancel_no_buzz", 32'(buzzer), 32'd0);
    buz_seen = 0;
    cycles(5);
    check("cancel_buzz_quiet", 32'(buz_seen), 32'd0);
    check("ctrl_rst_one_cycle", 32'(ctrl_rst), 32'd0);
    btn_cancel_raw = 1'b0;
    program_done = 1'b0;
    cycles(DEB + 2);

`ifdef WASH_PANEL_CHILD_LOCK_EN
    // Long start hold locks; cancel ignored; power drop aborts and clears lock
    press(0);
    check("cl_running", 32'(panel_state), 32'd1);
    btn_start_raw = 1'b1;
    cycles(DEB + LOCK_N + 4);
    btn_start_raw = 1'b0;
    cycles(DEB + 2);
    check("cl_set", 32'(child_lock), 32'd1);
    press(2);
    check("cl_cancel_ignored", 32'(panel_state), 32'd1);
    power_sw_raw = 1'b0;
    cycles(DEB + 2);
    check("cl_power_abort", 32'(panel_state), 32'd0);
    check("cl_cleared", 32'(child_lock), 32'd0);
    power_sw_raw = 1'b1;
    cycles(DEB + 2);
`else
    check("child_lock_tied", 32'(child_lock), 32'd0);
`endif

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if (power_sw_raw) begin
        if ($urandom_range(0, 99) < 1) power_sw_raw = 1'b0;
      end else if ($urandom_range(0, 99) < 15) power_sw_raw = 1'b1;
      if (door_sw_raw) begin
        if ($urandom_range(0, 99) < 2) door_sw_raw = 1'b0;
      end else if ($urandom_range(0, 99) < 15) door_sw_raw = 1'b1;
      if ($urandom_range(0, 99) < 5)  soap_sw_raw = ~soap_sw_raw;
      if ($urandom_range(0, 99) < 7)  btn_start_raw = ~btn_start_raw;
      if ($urandom_range(0, 99) < 7)  btn_prog_raw = ~btn_prog_raw;
      if ($urandom_range(0, 99) < 4)  btn_cancel_raw = ~btn_cancel_raw;
      if ($urandom_range(0, 99) < 6)  program_done = ~program_done;
      if ($urandom_range(0, 99) < 10) soap_warning = ~soap_warning;
      if ($urandom_range(0, 99) < 30) timer_display = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
